// File: rtl/asi_rw_arb.sv
// ---------------------------------------------------------------------------
// asi_rw_arb
//   Arbitrates ownership of a single user-memory port between a read side
//   and a write side. A side asks for ownership with its request, gets a
//   grant one cycle later, and keeps it until it issues its final beat.
//   Completed bursts are counted per side. Protocol violations raise a
//   sticky error flag.
//
// Handshake semantics (request / grant / beat):
//   - usr_xrequest is a level. It means "this side has work pending". It may
//     drop at any time, including in the same cycle as the first beat.
//   - usr_xgrant is a registered decode of the arbiter state. A side may only
//     issue beats (usr_xe) while its grant is high.
//   - usr_xlast qualifies usr_xe. The beat with both high is the final beat.
//     Ownership is released on the clock edge that samples that beat.
//
// Parameters
//   ASI_ARB : priority when both requests arrive while idle (0 = write, 1 = read)
//   CNTW    : width of the completed-burst counters (the counters wrap)
//
// Ports
//   usr_clk, usr_reset_n        : clock, and synchronous active-low reset
//   usr_rrequest/usr_re/usr_rlast : read-side request, beat, and last qualifier
//   usr_rgrant                  : read side owns the memory
//   usr_wrequest/usr_we/usr_wlast : write-side request, beat, and last qualifier
//   usr_wgrant                  : write side owns the memory
//   arb_err                     : sticky protocol-error flag
//   rd_bursts, wr_bursts        : completed-burst counters
//
// State visibility: the grant pair is a one-hot decode of the FSM state.
// IDLE = 00, RD = rgrant, WR = wgrant. A checker can rebuild the state from
// the two grants alone.
// ---------------------------------------------------------------------------
module asi_rw_arb #(
    parameter bit ASI_ARB = 1'b0,
    parameter int CNTW    = 16
) (
    input  logic            usr_clk,
    input  logic            usr_reset_n,
    input  logic            usr_rrequest,
    input  logic            usr_re,
    input  logic            usr_rlast,
    output logic            usr_rgrant,
    input  logic            usr_wrequest,
    input  logic            usr_we,
    input  logic            usr_wlast,
    output logic            usr_wgrant,
    output logic            arb_err,
    output logic [CNTW-1:0] rd_bursts,
    output logic [CNTW-1:0] wr_bursts
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_t;

    arb_state_t state;
    arb_state_t state_nxt;

    logic rd_done;
    logic wr_done;
    logic proto_err;

    // A last beat only completes a burst when it comes from the current
    // owner. Beats from the other side are errors and are otherwise ignored.
    assign rd_done = (state == RD) && usr_re && usr_rlast;
    assign wr_done = (state == WR) && usr_we && usr_wlast;

    assign proto_err = (usr_re && (state != RD)) ||
                       (usr_we && (state != WR)) ||
                       (usr_rlast && !usr_re)    ||
                       (usr_wlast && !usr_we);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (usr_rrequest && usr_wrequest) begin
                    state_nxt = ASI_ARB ? RD : WR;
                end else if (usr_rrequest) begin
                    state_nxt = RD;
                end else if (usr_wrequest) begin
                    state_nxt = WR;
                end
            end
            RD: begin
                // On release, hand over to the other side first so that
                // neither side can starve the other.
                if (rd_done) begin
                    if (usr_wrequest) begin
                        state_nxt = WR;
                    end else if (usr_rrequest) begin
                        state_nxt = RD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            WR: begin
                if (wr_done) begin
                    if (usr_rrequest) begin
                        state_nxt = RD;
                    end else if (usr_wrequest) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) begin
            state     <= IDLE;
            arb_err   <= 1'b0;
            rd_bursts <= '0;
            wr_bursts <= '0;
        end else begin
            state <= state_nxt;
            if (rd_done) begin
                rd_bursts <= rd_bursts + CNTW'(1);
            end
            if (wr_done) begin
                wr_bursts <= wr_bursts + CNTW'(1);
            end
            if (proto_err) begin
                arb_err <= 1'b1;
            end
        end
    end

    // The grants decode the state register directly, so no input has a
    // combinational path to either grant.
    assign usr_rgrant = (state == RD);
    assign usr_wgrant = (state == WR);

endmodule

// File: tb/tb_asi_rw_arb.sv
// ---------------------------------------------------------------------------
// tb_asi_rw_arb
//   Runs two arbiters side by side:
//     dut0: write priority, 16-bit counters
//     dut1: read priority, 4-bit counters
//   Each instance has its own inputs and its own reference model.
//
//   The model tracks three things per instance:
//     - the current owner (none / read / write)
//     - the sticky error flag
//     - the burst totals
//   It applies the ownership rules directly at the start of every cycle.
//   After the edge, every DUT output is compared against the model.
//   Directed scenarios then add explicit checks on top.
// ---------------------------------------------------------------------------
module tb_asi_rw_arb;

    localparam int OWN_NONE = 0;
    localparam int OWN_RD   = 1;
    localparam int OWN_WR   = 2;

    // ---------------- clock / reset ----------------
    logic usr_clk = 1'b0;
    logic usr_reset_n;
    always #5 usr_clk = ~usr_clk;

    // ---------------- per-instance signals ----------------
    logic rreq [2];
    logic re [2];
    logic rlast [2];
    logic wreq [2];
    logic we [2];
    logic wlast [2];
    logic rgrant [2];
    logic wgrant [2];
    logic err [2];
    logic [15:0] rdb0;
    logic [15:0] wrb0;
    logic [3:0] rdb1;
    logic [3:0] wrb1;

    asi_rw_arb #(.ASI_ARB(1'b0), .CNTW(16)) dut0 (
        .usr_clk      (usr_clk),
        .usr_reset_n  (usr_reset_n),
        .usr_rrequest (rreq[0]),
        .usr_re       (re[0]),
        .usr_rlast    (rlast[0]),
        .usr_rgrant   (rgrant[0]),
        .usr_wrequest (wreq[0]),
        .usr_we       (we[0]),
        .usr_wlast    (wlast[0]),
        .usr_wgrant   (wgrant[0]),
        .arb_err      (err[0]),
        .rd_bursts    (rdb0),
        .wr_bursts    (wrb0)
    );

    asi_rw_arb #(.ASI_ARB(1'b1), .CNTW(4)) dut1 (
        .usr_clk      (usr_clk),
        .usr_reset_n  (usr_reset_n),
        .usr_rrequest (rreq[1]),
        .usr_re       (re[1]),
        .usr_rlast    (rlast[1]),
        .usr_rgrant   (rgrant[1]),
        .usr_wrequest (wreq[1]),
        .usr_we       (we[1]),
        .usr_wlast    (wlast[1]),
        .usr_wgrant   (wgrant[1]),
        .arb_err      (err[1]),
        .rd_bursts    (rdb1),
        .wr_bursts    (wrb1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    int m_owner [2];
    bit m_err [2];
    int m_rd [2];
    int m_wr [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int counter_mod(input int i);
        return (i == 0) ? 65536 : 16;
    endfunction

    // Ownership rules.
    // From idle, a single requester wins outright. When both ask, the
    // configured priority decides. An owner keeps the memory until its final
    // beat. On release, the other side goes first if it is asking, then the
    // same side again if it is still asking, otherwise nobody.
    function automatic int next_owner(input int owner, input bit rq, input bit wq,
                                      input bit released, input bit read_wins);
        int other;
        bit other_req;
        bit self_req;
        if (owner == OWN_NONE) begin
            if (rq && wq) return read_wins ? OWN_RD : OWN_WR;
            if (rq) return OWN_RD;
            if (wq) return OWN_WR;
            return OWN_NONE;
        end
        if (!released) return owner;
        other     = (owner == OWN_RD) ? OWN_WR : OWN_RD;
        other_req = (other == OWN_RD) ? rq : wq;
        self_req  = (owner == OWN_RD) ? rq : wq;
        if (other_req) return other;
        if (self_req) return owner;
        return OWN_NONE;
    endfunction

    task automatic model_step(input int i);
        bit rd_done;
        bit wr_done;
        if (!usr_reset_n) begin
            m_owner[i] = OWN_NONE;
            m_err[i]   = 1'b0;
            m_rd[i]    = 0;
            m_wr[i]    = 0;
            return;
        end
        if ((re[i] && m_owner[i] != OWN_RD) || (we[i] && m_owner[i] != OWN_WR) ||
            (rlast[i] && !re[i]) || (wlast[i] && !we[i])) begin
            m_err[i] = 1'b1;
        end
        rd_done = (m_owner[i] == OWN_RD) && re[i] && rlast[i];
        wr_done = (m_owner[i] == OWN_WR) && we[i] && wlast[i];
        if (rd_done) m_rd[i] = (m_rd[i] + 1) % counter_mod(i);
        if (wr_done) m_wr[i] = (m_wr[i] + 1) % counter_mod(i);
        m_owner[i] = next_owner(m_owner[i], rreq[i], wreq[i], rd_done || wr_done, i == 1);
    endtask

    task automatic check_dut(input int i);
        logic [31:0] obs_rd;
        logic [31:0] obs_wr;
        obs_rd = (i == 0) ? 32'(rdb0) : 32'(rdb1);
        obs_wr = (i == 0) ? 32'(wrb0) : 32'(wrb1);
        check($sformatf("rgrant%0d", i), 32'(rgrant[i]), 32'(m_owner[i] == OWN_RD));
        check($sformatf("wgrant%0d", i), 32'(wgrant[i]), 32'(m_owner[i] == OWN_WR));
        check($sformatf("arb_err%0d", i), 32'(err[i]), 32'(m_err[i]));
        check($sformatf("rd_bursts%0d", i), obs_rd, m_rd[i]);
        check($sformatf("wr_bursts%0d", i), obs_wr, m_wr[i]);
        check($sformatf("overlap%0d", i), 32'(rgrant[i] & wgrant[i]), 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    // One cycle: the model absorbs the inputs about to be sampled, the edge
    // happens, then the outputs are compared 1 ns later.
    task automatic tick();
        for (int i = 0; i < 2; i++) model_step(i);
        @(posedge usr_clk);
        #1;
        for (int i = 0; i < 2; i++) check_dut(i);
    endtask

    task automatic clear_beats();
        for (int i = 0; i < 2; i++) begin
            re[i] = 1'b0;
            rlast[i] = 1'b0;
            we[i] = 1'b0;
            wlast[i] = 1'b0;
        end
    endtask

    task automatic set_reqs(input bit rq, input bit wq);
        for (int i = 0; i < 2; i++) begin
            rreq[i] = rq;
            wreq[i] = wq;
        end
    endtask

    // The current owner (as the model sees it) issues one beat.
    task automatic owner_beat(input int i, input bit last);
        if (m_owner[i] == OWN_RD) begin
            re[i] = 1'b1;
            rlast[i] = last;
        end else if (m_owner[i] == OWN_WR) begin
            we[i] = 1'b1;
            wlast[i] = last;
        end
    endtask

    task automatic drop_owner_req(input int i);
        if (m_owner[i] == OWN_RD) rreq[i] = 1'b0;
        if (m_owner[i] == OWN_WR) wreq[i] = 1'b0;
    endtask

    task automatic do_reset();
        clear_beats();
        set_reqs(1'b0, 1'b0);
        usr_reset_n = 1'b0;
        tick();
        usr_reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = OWN_NONE;
            m_err[i] = 1'b0;
            m_rd[i] = 0;
            m_wr[i] = 0;
        end
        clear_beats();
        set_reqs(1'b0, 1'b0);
        usr_reset_n = 1'b0;

        // Reset state.
        do_reset();
        check("reset_rgrant", 32'(rgrant[0]), 32'd0);
        check("reset_err", 32'(err[1]), 32'd0);

        // Single 4-beat read. The request drops together with the first beat.
        rreq[0] = 1'b1; rreq[1] = 1'b1;
        tick();
        check("single_rd_grant_c1", 32'(rgrant[0]), 32'd1);
        tick();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 2; i++) begin
                rreq[i] = 1'b0;
                re[i] = 1'b1;
                rlast[i] = (b == 3);
            end
            tick();
            if (b < 3) check("single_rd_hold", 32'(rgrant[0]), 32'd1);
        end
        clear_beats();
        check("single_rd_release", 32'(rgrant[0]), 32'd0);
        check("single_rd_count", 32'(rdb0), 32'd1);

        // Contention: dut0 favours write, dut1 favours read.
        do_reset();
        set_reqs(1'b1, 1'b1);
        tick();
        check("contend_w_first", 32'(wgrant[0]), 32'd1);
        check("contend_r_wait", 32'(rgrant[0]), 32'd0);
        check("contend_r_first", 32'(rgrant[1]), 32'd1);
        check("contend_w_wait", 32'(wgrant[1]), 32'd0);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 2; i++) begin
                if (b == 0) drop_owner_req(i);
                owner_beat(i, b == 2);
            end
            tick();
            clear_beats();
        end
        check("contend_handoff_r", 32'(rgrant[0]), 32'd1);
        check("contend_handoff_w", 32'(wgrant[1]), 32'd1);
        for (int i = 0; i < 2; i++) begin
            drop_owner_req(i);
            owner_beat(i, 1'b1);
        end
        tick();
        clear_beats();
        check("contend_idle0", 32'(rgrant[0] | wgrant[0]), 32'd0);
        check("contend_idle1", 32'(rgrant[1] | wgrant[1]), 32'd0);

        // Alternation: six single-beat bursts with both requests held high.
        do_reset();
        set_reqs(1'b1, 1'b1);
        tick();
        for (int k = 0; k < 6; k++) begin
            check("alt_seq0", 32'(wgrant[0]), 32'(k % 2 == 0));
            check("alt_seq1", 32'(rgrant[1]), 32'(k % 2 == 0));
            if (k == 5) set_reqs(1'b0, 1'b0);
            for (int i = 0; i < 2; i++) owner_beat(i, 1'b1);
            tick();
            clear_beats();
        end
        check("alt_rd0", 32'(rdb0), 32'd3);
        check("alt_wr0", 32'(wrb0), 32'd3);
        check("alt_rd1", 32'(rdb1), 32'd3);
        check("alt_wr1", 32'(wrb1), 32'd3);

        // Error stickiness, then reset in the middle of a write burst.
        do_reset();
        set_reqs(1'b0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            wreq[i] = 1'b0;
            we[i] = 1'b1;
            re[i] = 1'b1;
        end
        tick();
        clear_beats();
        check("err_set", 32'(err[0]), 32'd1);
        check("err_state_kept", 32'(wgrant[0]), 32'd1);
        check("err_cnt_kept", 32'(rdb0), 32'd0);
        for (int i = 0; i < 2; i++) we[i] = 1'b1;
        tick();
        check("err_sticky", 32'(err[1]), 32'd1);
        set_reqs(1'b0, 1'b1);
        usr_reset_n = 1'b0;
        tick();
        check("rst_mid_grant", 32'(wgrant[0]), 32'd0);
        check("rst_mid_err", 32'(err[0]), 32'd0);
        check("rst_mid_cnt", 32'(wrb1), 32'd0);
        usr_reset_n = 1'b1;
        clear_beats();
        tick();
        check("rst_regrant", 32'(wgrant[0]), 32'd1);
        for (int i = 0; i < 2; i++) begin
            wreq[i] = 1'b0;
            owner_beat(i, 1'b1);
        end
        tick();
        clear_beats();

        // Counter wrap: 17 read bursts, so the 4-bit counter wraps to 1.
        do_reset();
        set_reqs(1'b1, 1'b0);
        tick();
        for (int n = 0; n < 17; n++) begin
            if (n == 16) set_reqs(1'b0, 1'b0);
            for (int i = 0; i < 2; i++) owner_beat(i, 1'b1);
            tick();
            clear_beats();
        end
        check("wrap_rd4", 32'(rdb1), 32'd1);
        check("wrap_rd16", 32'(rdb0), 32'd17);

        // Random traffic: the owner issues most beats. Illegal beats and
        // resets are rare.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            clear_beats();
            usr_reset_n = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < 2; i++) begin
                rreq[i] = ($urandom_range(0, 1) == 1);
                wreq[i] = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 1) == 1) owner_beat(i, $urandom_range(0, 2) == 0);
                if ($urandom_range(0, 99) == 0) re[i] = 1'b1;
                if ($urandom_range(0, 99) == 0) we[i] = 1'b1;
                if ($urandom_range(0, 149) == 0) rlast[i] = 1'b1;
                if ($urandom_range(0, 149) == 0) wlast[i] = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
